fp_extreme_tracker: RTL and testbench
=====================================

FP_EXTREME_TRACKER -- requirements
Module: fp_extreme_tracker

Interface
REQ-001 The block SHALL have parameter EXP_W, default 4, meaning exponent field width.
REQ-002 The block SHALL have parameter FRAC_W, default 8, meaning fraction field width.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning sample counter and index width.
REQ-004 The block SHALL define local W = 1+EXP_W+FRAC_W; word format is {sign, exp, frac}, sign-magnitude, sign=1 negative.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic rises on clk.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port s_valid, input, 1, input sample valid.
REQ-008 The block SHALL have port s_ready, output, 1, block accepts a sample this cycle.
REQ-009 The block SHALL have ports s_data (input, W, sample), s_last (input, 1, final sample of packet) and mode (input, 1, 0=track max, 1=track min).
REQ-010 The block SHALL have ports m_valid (output, 1, result valid) and m_ready (input, 1, downstream accepts result).
REQ-011 The block SHALL have ports m_data (output, W, extreme value), m_index (output, CNT_W, zero-based position of extreme) and m_count (output, CNT_W, samples in packet).

Function
REQ-012 The block SHALL transfer a sample only when s_valid and s_ready are both 1 on a rising clk edge.
REQ-013 The block SHALL implement FSM IDLE -> ACCUM -> HOLD -> IDLE.
REQ-014 In IDLE, s_ready=1; an accepted sample SHALL load the extreme register with s_data, set index=0 and count=1, and latch mode for the whole packet.
REQ-015 The block SHALL go from IDLE to ACCUM on an accepted non-last sample, and directly to HOLD on an accepted sample with s_last=1.
REQ-016 In ACCUM, s_ready=1; each accepted sample SHALL be compared against the stored extreme and SHALL replace it (value and index=count) only if strictly greater (max mode) or strictly less (min mode).
REQ-017 Ties SHALL keep the earlier sample, so the earliest index wins.
REQ-018 Comparison SHALL be sign-magnitude: both positive means larger {exp,frac} is greater; both negative means smaller {exp,frac} is greater; mixed signs means the positive value is greater.
REQ-019 +0 (all zero) and -0 (sign only) SHALL compare equal, unlike the earlier fixed 13-bit comparator.
REQ-020 An accepted sample with s_last=1 in ACCUM SHALL update the extreme and count, then move to HOLD.
REQ-021 In HOLD, s_ready=0 and m_valid=1, with m_data, m_index and m_count stable until m_valid&&m_ready.
REQ-022 The result handshake SHALL return the FSM to IDLE; a new packet is accepted no earlier than the following cycle.
REQ-023 Latency SHALL be exactly 1 cycle: m_valid rises on the edge that accepts the s_last sample.
REQ-024 count SHALL saturate at 2^CNT_W-1; samples beyond saturation are still compared and, if they win, record index 2^CNT_W-1.
REQ-025 Changes to mode while in ACCUM or HOLD SHALL be ignored.

Reset
REQ-026 While reset=1 on an edge, the FSM SHALL go to IDLE, with m_valid=0, m_data=0, m_index=0, m_count=0, and s_ready=0 during the reset cycle.
REQ-027 A reset during ACCUM or HOLD SHALL discard the partial or pending result with no m_valid pulse.

Structure
REQ-028 Package fp_pkg SHALL hold the FSM state typedef, the mode enum (MODE_MAX, MODE_MIN) and the default EXP_W/FRAC_W constants.
REQ-029 Compare logic SHALL live in sub-module fp_cmp, combinational and parametrised on EXP_W/FRAC_W, with outputs agtb and aeqb; fp_extreme_tracker SHALL instantiate it once.

Verification (EXP_W=4, FRAC_W=8)
REQ-030 Max, packet 0x0180, 0x1280, 0x0300(last), m_ready=1: m_valid the cycle after last, m_data=0x0300, m_index=2, m_count=3.
REQ-031 Min, packet 0x0180, 0x1280, 0x1100(last): m_data=0x1280, m_index=1 (negative with larger magnitude is smaller).
REQ-032 Max, packet 0x1000, 0x0000(last): m_data=0x1000, m_index=0 (±0 tie, earliest kept).
REQ-033 Single-sample packet 0x0A55 with s_last, m_ready held 0 for 5 cycles: m_valid high and outputs stable for all 5 cycles, s_ready=0, then IDLE one cycle after m_ready=1.
REQ-034 Reset asserted mid-packet after 2 samples, then packet 0x0010(last): no result for the aborted packet; the result is m_data=0x0010, m_count=1.
REQ-035 CNT_W=2, max mode, 5 samples ascending 0x0001..0x0005: m_count=3, m_index=3, m_data=0x0005.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and defaults for the floating-point extreme tracker.
//   state_e     - tracker FSM states (IDLE -> ACCUM -> HOLD -> IDLE)
//   mode_e      - packet tracking mode (MODE_MAX / MODE_MIN)
//   DEF_EXP_W   - default exponent field width
//   DEF_FRAC_W  - default fraction field width
package fp_pkg;

  localparam int DEF_EXP_W  = 4;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

endpackage

// File: rtl/fp_cmp.sv
// fp_cmp: combinational sign-magnitude comparator for {sign, exp, frac} words.
//   a, b  - operands (sign=1 means negative)
//   agtb  - 1 when a is strictly greater than b
//   aeqb  - 1 when a equals b; +0 and -0 are treated as equal
module fp_cmp
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  agtb,
  output logic                  aeqb
);

  localparam int MW = EXP_W + FRAC_W;

  logic          sign_a;
  logic          sign_b;
  logic [MW-1:0] mag_a;
  logic [MW-1:0] mag_b;

  assign sign_a = a[MW];
  assign sign_b = b[MW];
  assign mag_a  = a[MW-1:0];
  assign mag_b  = b[MW-1:0];

  always_comb begin
    agtb = 1'b0;
    aeqb = 1'b0;
    if ((mag_a == '0) && (mag_b == '0)) begin
      // Zero of either sign: equal regardless of the sign bits.
      aeqb = 1'b1;
    end else if (a == b) begin
      aeqb = 1'b1;
    end else if (sign_a != sign_b) begin
      // Mixed signs: the non-negative operand wins. A lone -0 against a
      // positive value correctly loses here, and +0 beats any negative.
      agtb = !sign_a;
    end else if (!sign_a) begin
      agtb = (mag_a > mag_b);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      agtb = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/fp_extreme_tracker.sv
// fp_extreme_tracker: finds the maximum or minimum sample of a packet and
// reports its value, zero-based position and the packet's sample count.
//   clk, reset        - clock and synchronous active-high reset
//   s_valid/s_ready   - input sample handshake
//   s_data, s_last    - sample word {sign, exp, frac} and end-of-packet flag
//   mode              - 0 tracks maximum, 1 tracks minimum (latched on first sample)
//   m_valid/m_ready   - result handshake
//   m_data            - extreme value of the packet
//   m_index           - position of the extreme (earliest wins on ties)
//   m_count           - samples in the packet, saturating at all-ones
module fp_extreme_tracker
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [EXP_W+FRAC_W:0]     s_data,
  input  logic                      s_last,
  input  logic                      mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [EXP_W+FRAC_W:0]     m_data,
  output logic [CNT_W-1:0]          m_index,
  output logic [CNT_W-1:0]          m_count
);

  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_reg, state_next;
  mode_e            mode_reg, mode_next;
  logic [W-1:0]     ext_reg, ext_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  logic new_gt;
  logic new_eq;
  logic new_wins;
  logic accept;

  // Sample is operand a, stored extreme is operand b.
  fp_cmp #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_cmp (
    .a    (s_data),
    .b    (ext_reg),
    .agtb (new_gt),
    .aeqb (new_eq)
  );

  // Strict comparison in both modes so ties keep the earlier sample.
  assign new_wins = (mode_reg == MODE_MAX) ? new_gt : (!new_gt && !new_eq);

  // Handshake outputs are suppressed while reset is asserted.
  assign s_ready = !reset && (state_reg != ST_HOLD);
  assign m_valid = !reset && (state_reg == ST_HOLD);
  assign accept  = s_valid && s_ready;

  // Saturating count; the pre-increment value doubles as the new sample's
  // index, so saturated samples that win record index CNT_MAX.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);

  assign m_data  = ext_reg;
  assign m_index = idx_reg;
  assign m_count = cnt_reg;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    ext_next   = ext_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          ext_next   = s_data;
          idx_next   = '0;
          cnt_next   = CNT_W'(1);
          mode_next  = mode_e'(mode);
          state_next = s_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_next = cnt_inc;
          if (new_wins) begin
            ext_next = s_data;
            idx_next = cnt_reg;
          end
          if (s_last) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (m_valid && m_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_MAX;
      ext_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      ext_reg   <= ext_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fp_extreme_tracker.sv
// tb_fp_extreme_tracker: self-checking bench for fp_extreme_tracker.
// A main instance (defaults) is checked through a scoreboard queue that a
// monitor drains on each result handshake; a CNT_W=2 instance covers count
// saturation.
module tb_fp_extreme_tracker;

  typedef struct packed {
    logic [12:0] data;
    logic [7:0]  idx;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        s_valid, s_ready, s_last, mode;
  logic [12:0] s_data;
  logic        m_valid, m_ready;
  logic [12:0] m_data;
  logic [7:0]  m_index, m_count;

  logic        s2_valid, s2_ready, s2_last, mode2;
  logic [12:0] s2_data;
  logic        m2_valid, m2_ready;
  logic [12:0] m2_data;
  logic [1:0]  m2_index, m2_count;

  int   vec_count;
  int   err_count;
  exp_t exp_q[$];
  exp_t exp2_q[$];
  logic [12:0] pkt[16];

  fp_extreme_tracker #(.EXP_W(4), .FRAC_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_count(m_count)
  );

  fp_extreme_tracker #(.EXP_W(4), .FRAC_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data), .s_last(s2_last), .mode(mode2),
    .m_valid(m2_valid), .m_ready(m2_ready),
    .m_data(m2_data), .m_index(m2_index), .m_count(m2_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed value of a sign-magnitude word; -0 folds onto 0.
  function automatic int sval(input logic [12:0] x);
    int m;
    m = int'(x[11:0]);
    return x[12] ? -m : m;
  endfunction

  // Reference result for pkt[0..n-1] with counts saturating at cmax.
  function automatic exp_t model(input int n, input logic md, input int cmax);
    exp_t r;
    int best, cnt, v;
    best   = sval(pkt[0]);
    r.data = pkt[0];
    r.idx  = 8'd0;
    cnt    = 1;
    for (int i = 1; i < n; i++) begin
      v = sval(pkt[i]);
      if (md ? (v < best) : (v > best)) begin
        best   = v;
        r.data = pkt[i];
        r.idx  = 8'(cnt);
      end
      if (cnt < cmax) cnt++;
    end
    r.cnt = 8'(cnt);
    return r;
  endfunction

  // Scoreboard monitor: one line per completed result transaction.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      exp_t e;
      vec_count++;
      if (exp_q.size() == 0) begin
        err_count++;
        $display("FAIL unexpected_result: got data=%h idx=%0d cnt=%0d, required no result",
                 m_data, m_index, m_count);
      end else begin
        e = exp_q.pop_front();
        $display("result data=%h idx=%0d cnt=%0d (expected %h/%0d/%0d)",
                 m_data, m_index, m_count, e.data, e.idx, e.cnt);
        vec_count += 2;
        if (m_data !== e.data) begin
          err_count++;
          $display("FAIL result_data: got %h, required %h", m_data, e.data);
        end
        if (m_index !== e.idx) begin
          err_count++;
          $display("FAIL result_index: got %0d, required %0d", m_index, e.idx);
        end
        if (m_count !== e.cnt) begin
          err_count++;
          $display("FAIL result_count: got %0d, required %0d", m_count, e.cnt);
        end
      end
    end
  end

  // Drives pkt[0..n-1] back to back starting at posedge+1; returns at
  // posedge+1 after the final sample's edge. Mode is randomised after the
  // first sample since the DUT must ignore it mid-packet.
  task automatic drive_pkt(input int n, input logic md, input bit with_last);
    if (with_last) exp_q.push_back(model(n, md, 255));
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = with_last && (i == n - 1);
      mode    = (i == 0) ? md : logic'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_count += 5;
    if (s_ready !== 1'b0) begin err_count++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
    if (m_valid !== 1'b0) begin err_count++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    if (m_data !== 13'h0) begin err_count++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
    if (m_index !== 8'h0) begin err_count++; $display("FAIL reset_m_index: got %0d, required 0", m_index); end
    if (m_count !== 8'h0) begin err_count++; $display("FAIL reset_m_count: got %0d, required 0", m_count); end
    reset = 1'b0;
    #1;
    vec_count++;
    if (s_ready !== 1'b1) begin err_count++; $display("FAIL idle_s_ready: got %b, required 1", s_ready); end
  endtask

  // Common tail for a packet accepted with m_ready=1: valid right after the
  // last edge, idle again one edge later.
  task automatic test_packet(input string name, input int n, input logic md);
    m_ready = 1'b1;
    drive_pkt(n, md, 1'b1);
    vec_count += 2;
    if (m_valid !== 1'b1) begin err_count++; $display("FAIL %s_latency: m_valid got %b, required 1", name, m_valid); end
    if (s_ready !== 1'b0) begin err_count++; $display("FAIL %s_hold_ready: s_ready got %b, required 0", name, s_ready); end
    @(posedge clk); #1;
    vec_count += 2;
    if (m_valid !== 1'b0) begin err_count++; $display("FAIL %s_release: m_valid got %b, required 0", name, m_valid); end
    if (s_ready !== 1'b1) begin err_count++; $display("FAIL %s_idle: s_ready got %b, required 1", name, s_ready); end
  endtask

  task automatic test_max;
    pkt[0] = 13'h0180; pkt[1] = 13'h1280; pkt[2] = 13'h0300;
    test_packet("max", 3, 1'b0);
  endtask

  task automatic test_min;
    pkt[0] = 13'h0180; pkt[1] = 13'h1280; pkt[2] = 13'h1100;
    test_packet("min", 3, 1'b1);
  endtask

  task automatic test_zero_tie;
    pkt[0] = 13'h1000; pkt[1] = 13'h0000;
    test_packet("zero_tie_max", 2, 1'b0);
    pkt[0] = 13'h0000; pkt[1] = 13'h1000;
    test_packet("zero_tie_min", 2, 1'b1);
  endtask

  task automatic test_hold_stall;
    m_ready = 1'b0;
    pkt[0]  = 13'h0A55;
    drive_pkt(1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      vec_count += 5;
      if (m_valid !== 1'b1)   begin err_count++; $display("FAIL stall_valid[%0d]: got %b, required 1", k, m_valid); end
      if (s_ready !== 1'b0)   begin err_count++; $display("FAIL stall_ready[%0d]: got %b, required 0", k, s_ready); end
      if (m_data !== 13'h0A55) begin err_count++; $display("FAIL stall_data[%0d]: got %h, required 0a55", k, m_data); end
      if (m_index !== 8'd0)   begin err_count++; $display("FAIL stall_index[%0d]: got %0d, required 0", k, m_index); end
      if (m_count !== 8'd1)   begin err_count++; $display("FAIL stall_count[%0d]: got %0d, required 1", k, m_count); end
      if (k < 4) begin @(posedge clk); #1; end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    vec_count += 2;
    if (m_valid !== 1'b0) begin err_count++; $display("FAIL stall_release: m_valid got %b, required 0", m_valid); end
    if (s_ready !== 1'b1) begin err_count++; $display("FAIL stall_idle: s_ready got %b, required 1", s_ready); end
  endtask

  task automatic test_reset_abort;
    m_ready = 1'b1;
    pkt[0] = 13'h0500; pkt[1] = 13'h0700;
    drive_pkt(2, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    vec_count += 2;
    if (m_valid !== 1'b0) begin err_count++; $display("FAIL abort_valid: got %b, required 0", m_valid); end
    if (s_ready !== 1'b0) begin err_count++; $display("FAIL abort_ready: got %b, required 0", s_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    vec_count += 2;
    if (m_valid !== 1'b0) begin err_count++; $display("FAIL abort_no_result: got %b, required 0", m_valid); end
    if (m_count !== 8'd0) begin err_count++; $display("FAIL abort_count: got %0d, required 0", m_count); end
    pkt[0] = 13'h0010;
    test_packet("after_abort", 1, 1'b0);
  endtask

  task automatic test_saturate;
    exp_t e;
    pkt[0] = 13'h0001; pkt[1] = 13'h0002; pkt[2] = 13'h0003; pkt[3] = 13'h0004; pkt[4] = 13'h0005;
    exp2_q.push_back(model(5, 1'b0, 3));
    m2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s2_valid = 1'b1;
      s2_data  = pkt[i];
      s2_last  = (i == 4);
      mode2    = 1'b0;
      @(posedge clk); #1;
    end
    s2_valid = 1'b0;
    s2_last  = 1'b0;
    e = exp2_q.pop_front();
    $display("result2 data=%h idx=%0d cnt=%0d (expected %h/%0d/%0d)",
             m2_data, m2_index, m2_count, e.data, e.idx, e.cnt);
    vec_count += 4;
    if (m2_valid !== 1'b1) begin err_count++; $display("FAIL sat_valid: got %b, required 1", m2_valid); end
    if (m2_data !== e.data) begin err_count++; $display("FAIL sat_data: got %h, required %h", m2_data, e.data); end
    if (m2_index !== e.idx[1:0]) begin err_count++; $display("FAIL sat_index: got %0d, required %0d", m2_index, e.idx); end
    if (m2_count !== e.cnt[1:0]) begin err_count++; $display("FAIL sat_count: got %0d, required %0d", m2_count, e.cnt); end
    @(posedge clk); #1;
    vec_count++;
    if (m2_valid !== 1'b0) begin err_count++; $display("FAIL sat_release: got %b, required 0", m2_valid); end
  endtask

  // Random packets over a tiny value set (many ties, both zeros), random
  // mode, random downstream stalls.
  task automatic test_random;
    for (int p = 0; p < 20; p++) begin
      int n;
      int stall;
      logic md;
      logic [31:0] rnd;
      n  = $urandom_range(1, 7);
      md = logic'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        rnd    = $urandom;
        pkt[i] = {rnd[0], 2'b00, rnd[2:1], 6'b000000, rnd[4:3]};
      end
      stall   = $urandom_range(0, 3);
      m_ready = (stall == 0);
      drive_pkt(n, md, 1'b1);
      for (int k = 0; k < stall; k++) begin
        vec_count++;
        if (m_valid !== 1'b1) begin err_count++; $display("FAIL rand_hold[%0d]: m_valid got %b, required 1", p, m_valid); end
        @(posedge clk); #1;
      end
      vec_count++;
      if (m_valid !== 1'b1) begin err_count++; $display("FAIL rand_valid[%0d]: got %b, required 1", p, m_valid); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      vec_count++;
      if (m_valid !== 1'b0) begin err_count++; $display("FAIL rand_release[%0d]: got %b, required 0", p, m_valid); end
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    reset    = 1'b1;
    s_valid  = 1'b0; s_data  = '0; s_last  = 1'b0; mode  = 1'b0; m_ready  = 1'b1;
    s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0; mode2 = 1'b0; m2_ready = 1'b1;
    test_reset();
    test_max();
    test_min();
    test_zero_tie();
    test_hold_stall();
    test_reset_abort();
    test_saturate();
    test_random();
    repeat (2) @(posedge clk);
    #1;
    vec_count++;
    if (exp_q.size() != 0) begin
      err_count++;
      $display("FAIL missing_results: %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
